// File: rtl/ro_puf_measure.sv
// Ring-oscillator PUF measurement core: two selected oscillators are edge-counted
// over a fixed reference-clock window; the response bit compares the two counts.
module ro_puf_measure #(
   parameter int N_RO        = 16,
   parameter int SEL_W       = 4,
   parameter int CNT_W       = 12,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [SEL_W-1:0] select1,
   input  logic [SEL_W-1:0] select2,
   input  logic [N_RO-1:0]  ro_in,
   output logic [CNT_W-1:0] counter1_out,
   output logic [CNT_W-1:0] counter2_out,
   output logic [CNT_W-1:0] clockcounter_out,
   output logic             done,
   output logic             puf_out
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [N_RO-1:0]  r_sync [SYNC_STAGES];
   logic             r_hist1;
   logic             r_hist2;
   logic [CNT_W-1:0] r_cnt1;
   logic [CNT_W-1:0] r_cnt2;
   logic [CNT_W-1:0] r_clk_cnt;

   logic             w_mux1;
   logic             w_mux2;
   logic             w_edge1;
   logic             w_edge2;
   logic             w_done;
   logic             w_cnt_en;

   // Every oscillator bit is synchronized, so select changes never see a raw async signal.
   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            always_ff @(posedge clock or negedge reset) begin
               if (!reset) r_sync[gi] <= '0;
               else        r_sync[gi] <= ro_in;
            end
         end else begin : g_rest
            always_ff @(posedge clock or negedge reset) begin
               if (!reset) r_sync[gi] <= '0;
               else        r_sync[gi] <= r_sync[gi-1];
            end
         end
      end
   endgenerate

   assign w_mux1   = r_sync[SYNC_STAGES-1][select1];
   assign w_mux2   = r_sync[SYNC_STAGES-1][select2];
   assign w_edge1  = w_mux1 & ~r_hist1;
   assign w_edge2  = w_mux2 & ~r_hist2;
   assign w_done   = (r_clk_cnt == CNT_MAX);
   assign w_cnt_en = enable & ~w_done;

   // History tracks the mux even while disabled so re-enabling sees no stale edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_hist1 <= 1'b0;
         r_hist2 <= 1'b0;
      end else begin
         r_hist1 <= w_mux1;
         r_hist2 <= w_mux2;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_clk_cnt <= '0;
         r_cnt1    <= '0;
         r_cnt2    <= '0;
      end else if (w_cnt_en) begin
         r_clk_cnt <= r_clk_cnt + 1'b1;
         if (w_edge1 && (r_cnt1 != CNT_MAX)) r_cnt1 <= r_cnt1 + 1'b1;
         if (w_edge2 && (r_cnt2 != CNT_MAX)) r_cnt2 <= r_cnt2 + 1'b1;
      end
   end

   assign counter1_out     = r_cnt1;
   assign counter2_out     = r_cnt2;
   assign clockcounter_out = r_clk_cnt;
   assign done             = w_done;
   assign puf_out          = (r_cnt1 >= r_cnt2);

endmodule

// File: tb/tb_ro_puf_measure.sv
// Randomized bench for ro_puf_measure: a sample-history model predicts every output
// each cycle, and literal window results pin the model to the expected behaviour.
module tb_ro_puf_measure;

   localparam int MAXV = 4095;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [3:0]  select1 = '0;
   logic [3:0]  select2 = '0;
   logic [15:0] ro_in = '0;
   logic [11:0] counter1_out;
   logic [11:0] counter2_out;
   logic [11:0] clockcounter_out;
   logic        done;
   logic        puf_out;

   ro_puf_measure dut (
      .clock            (clock),
      .reset            (reset),
      .enable           (enable),
      .select1          (select1),
      .select2          (select2),
      .ro_in            (ro_in),
      .counter1_out     (counter1_out),
      .counter2_out     (counter2_out),
      .clockcounter_out (clockcounter_out),
      .done             (done),
      .puf_out          (puf_out)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // Waveform generator: half-period per bit in clocks, 0 means hold constant.
   int hp [16];
   int ph [16];

   // Model: ro_in samples taken at the last four clock edges (h0 = current edge).
   logic [15:0] h0, h1, h2, h3;
   int  m_cc, m_c1, m_c2;
   bit  e1, e2, ce;
   bit  ld_req = 1'b0;
   int  ld_val = 0;
   bit  skip_chk = 1'b0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         h0 = '0; h1 = '0; h2 = '0; h3 = '0;
         m_cc = 0; m_c1 = 0; m_c2 = 0;
      end else begin
         h3 = h2; h2 = h1; h1 = h0; h0 = ro_in;
         // An input level sampled two edges ago is visible now; rising if it was low one edge before that.
         e1 = h2[select1] & ~h3[select1];
         e2 = h2[select2] & ~h3[select2];
         ce = enable && (m_cc != MAXV);
         if (ld_req) m_c1 = ld_val;
         if (ce) begin
            m_cc = m_cc + 1;
            if (e1) m_c1 = (m_c1 < MAXV) ? m_c1 + 1 : MAXV;
            if (e2) m_c2 = (m_c2 < MAXV) ? m_c2 + 1 : MAXV;
         end
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         if (errors < 40) $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int got, input int lo, input int hi);
      checks++;
      if (got < lo || got > hi) begin
         errors++;
         if (errors < 40) $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
      end
   endtask

   always @(negedge clock) begin
      if (!skip_chk) begin
         chk("cyc_counter1", int'(counter1_out), m_c1);
         chk("cyc_counter2", int'(counter2_out), m_c2);
         chk("cyc_clockcounter", int'(clockcounter_out), m_cc);
         chk("cyc_done", int'(done), int'(m_cc == MAXV));
         chk("cyc_puf", int'(puf_out), int'(m_c1 >= m_c2));
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #2;
         for (int b = 0; b < 16; b++) begin
            if (hp[b] > 0) begin
               ph[b]++;
               if (ph[b] >= hp[b]) begin
                  ph[b] = 0;
                  ro_in[b] = ~ro_in[b];
               end
            end
         end
      end
   endtask

   // Assert reset between edges, load selects, release it with the given enable.
   task automatic restart(input logic [3:0] s1, input logic [3:0] s2, input logic en);
      @(posedge clock);
      #3 reset = 1'b0;
      select1 = s1;
      select2 = s2;
      enable  = 1'b0;
      for (int b = 0; b < 16; b++) ph[b] = 0;
      @(posedge clock);
      #2 reset = 1'b1;
      enable = en;
   endtask

   task automatic clear_waves();
      for (int b = 0; b < 16; b++) hp[b] = 0;
      ro_in = '0;
   endtask

   initial begin
      clear_waves();
      // Reset held while oscillators toggle.
      hp[0] = 4; hp[15] = 8;
      step(10);
      chk("rst_counter1", int'(counter1_out), 0);
      chk("rst_counter2", int'(counter2_out), 0);
      chk("rst_clockcounter", int'(clockcounter_out), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_puf", int'(puf_out), 1);
      $display("reset hold: counts=%0d/%0d puf=%0d", counter1_out, counter2_out, puf_out);

      // Full window, channel 1 period 8, channel 2 period 16.
      restart(4'd0, 4'd15, 1'b1);
      step(4100);
      chk("win_done", int'(done), 1);
      chk("win_clockcounter", int'(clockcounter_out), 4095);
      chk_rng("win_counter1", int'(counter1_out), 510, 512);
      chk_rng("win_counter2", int'(counter2_out), 254, 256);
      chk_rng("model_c1", m_c1, 510, 512);
      chk("win_puf", int'(puf_out), 1);
      step(100);
      chk("frozen_clockcounter", int'(clockcounter_out), 4095);
      chk_rng("frozen_counter1", int'(counter1_out), 510, 512);
      $display("full window: c1=%0d c2=%0d puf=%0d", counter1_out, counter2_out, puf_out);

      // Asynchronous reset mid-window, observed before any clock edge.
      restart(4'd0, 4'd15, 1'b1);
      step(500);
      chk_rng("mid_counter1_nonzero", int'(counter1_out), 55, 70);
      #1 reset = 1'b0;
      #1;
      chk("async_counter1", int'(counter1_out), 0);
      chk("async_counter2", int'(counter2_out), 0);
      chk("async_clockcounter", int'(clockcounter_out), 0);
      chk("async_puf", int'(puf_out), 1);
      step(2);
      $display("async reset: c1=%0d cc=%0d", counter1_out, clockcounter_out);

      // Swapped selects.
      restart(4'd15, 4'd0, 1'b1);
      step(4100);
      chk_rng("swap_counter1", int'(counter1_out), 254, 256);
      chk_rng("swap_counter2", int'(counter2_out), 510, 512);
      chk("swap_puf", int'(puf_out), 0);
      $display("swapped: c1=%0d c2=%0d puf=%0d", counter1_out, counter2_out, puf_out);

      // Enable gating.
      restart(4'd0, 4'd15, 1'b1);
      step(100);
      enable = 1'b0;
      step(200);
      chk("gate_clockcounter", int'(clockcounter_out), 100);
      chk_rng("gate_counter1", int'(counter1_out), 11, 13);
      enable = 1'b1;
      step(100);
      chk("regate_clockcounter", int'(clockcounter_out), 200);
      chk_rng("regate_counter1", int'(counter1_out), 23, 26);
      $display("enable gating: cc=%0d c1=%0d", clockcounter_out, counter1_out);

      // Equal selects on a randomly clocked oscillator.
      clear_waves();
      hp[5] = 2 + int'($urandom_range(7, 0));
      restart(4'd5, 4'd5, 1'b1);
      step(4100);
      chk("equal_counts", int'(counter1_out), int'(counter2_out));
      chk("equal_puf", int'(puf_out), 1);
      $display("equal select: hp=%0d c1=%0d c2=%0d", hp[5], counter1_out, counter2_out);

      // Constant inputs; enable waits until the constant-1 level has settled.
      clear_waves();
      ro_in[4] = 1'b1;
      hp[0] = 3;
      restart(4'd3, 4'd4, 1'b0);
      step(6);
      enable = 1'b1;
      step(4100);
      chk("const0_count", int'(counter1_out), 0);
      chk("const1_count", int'(counter2_out), 0);
      $display("static inputs: c1=%0d c2=%0d", counter1_out, counter2_out);

      // Fastest countable input, clock/4.
      clear_waves();
      hp[7] = 2; hp[0] = 4;
      restart(4'd7, 4'd0, 1'b1);
      step(4100);
      chk_rng("fast_counter1", int'(counter1_out), 1020, 1024);
      $display("clock/4 input: c1=%0d", counter1_out);

      // Saturation: preload channel 1 near full scale while edges keep arriving.
      restart(4'd7, 4'd0, 1'b1);
      step(1000);
      #1;
      skip_chk = 1'b1;
      force dut.r_cnt1 = 12'd4090;
      #1 release dut.r_cnt1;
      ld_val = 4090;
      ld_req = 1'b1;
      @(posedge clock);
      #1 ld_req = 1'b0;
      skip_chk = 1'b0;
      step(3200);
      chk("sat_counter1", int'(counter1_out), 4095);
      chk("sat_done", int'(done), 1);
      chk("sat_puf", int'(puf_out), 1);
      $display("saturation: c1=%0d c2=%0d", counter1_out, counter2_out);

      // Random oscillator mixes, selects and enable patterns.
      for (int r = 0; r < 3; r++) begin
         clear_waves();
         for (int b = 0; b < 16; b++) begin
            hp[b] = ($urandom_range(5, 0) == 0) ? 0 : 2 + int'($urandom_range(8, 0));
            ro_in[b] = 1'($urandom_range(1, 0));
         end
         restart(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 1'b1);
         for (int k = 0; k < 60; k++) begin
            enable = ($urandom_range(3, 0) != 0);
            step(20 + int'($urandom_range(80, 0)));
         end
         $display("random run %0d: sel=%0d/%0d c1=%0d c2=%0d cc=%0d puf=%0d",
                  r, select1, select2, counter1_out, counter2_out, clockcounter_out, puf_out);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ro_puf_measure.md
Name: ro_puf_measure

Overview:
- Measurement core of the ring-oscillator PUF.
- Two 16:1 selectors each pick one of 16 free-running ring-oscillator outputs. The block counts rising edges of each selected signal over a fixed window of 4095 reference-clock cycles.
- Outputs the two counts, the window counter, and a one-bit PUF response: 1 when count 1 is greater than or equal to count 2.
- Sits between the ring-oscillator array and the debug/readout logic.

Parameters:
- N_RO, 16, number of ring-oscillator inputs.
- SEL_W, 4, width of each select.
- CNT_W, 12, width of all counters; window length is 2^CNT_W-1 cycles.
- SYNC_STAGES, 2, synchronizer flops per oscillator input.

Ports:
- clock  in  1  reference clock; all state is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  measurement enable.
- select1  in  SEL_W  index of the oscillator for channel 1.
- select2  in  SEL_W  index of the oscillator for channel 2.
- ro_in  in  N_RO  oscillator outputs; bit i is oscillator i+1. Asynchronous to clock.
- counter1_out  out  CNT_W  edge count, channel 1.
- counter2_out  out  CNT_W  edge count, channel 2.
- clockcounter_out  out  CNT_W  window (reference-cycle) counter.
- done  out  1  window complete.
- puf_out  out  1  response.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0), immediate and asynchronous:
  - All counters, synchronizer flops and edge-history flops go to 0.
  - Outputs: counts 0, done=0, puf_out=1.
- Input synchronization: each ro_in bit passes through SYNC_STAGES flops, reset value 0.
- Selection: mux i outputs synchronized bit [select_i]. Select is binary-encoded, index 0 = ro_in[0], index 15 = ro_in[15]. Both selects may be equal.
- Edge detect: each channel keeps a one-flop history of its mux output. An edge is mux=1 while history=0.
  - A rising ro_in held high is counted on the 3rd rising clock edge after it is first sampled.
  - Inputs must have high and low phases of at least 2 clock periods to be counted exactly. Faster inputs undercount; this is not an error.
- Select changes mid-window are legal. They may add at most one spurious edge. Benches must keep selects stable during a window.
- Window counter:
  - Increments by 1 each clock while enable=1 and clockcounter_out != 4095.
  - Saturates at 4095.
  - done = (clockcounter_out == 4095), combinational.
- Count enable: cnt_en = enable & ~done, evaluated before the clock edge.
  - Channel counters increment on a clock edge when cnt_en=1 and an edge is detected.
  - The edge coincident with the window counter moving 4094→4095 is counted. Nothing after that is counted.
- Channel counters saturate at 4095; they never wrap.
- enable=0: all counters hold their values. Synchronizers and edge history keep running, so re-enabling does not count stale edges.
- After done, all counts are frozen until reset. There is no auto-restart.
- puf_out = (counter1_out >= counter2_out), combinational, unsigned compare. It is meaningful once done=1 and valid at all times.

Test Plan:
- Reset: hold reset=0 with ro_in toggling → all counts 0, done=0, puf_out=1. Assert reset=0 mid-window with counts nonzero → all counts 0 without waiting for a clock edge.
- Full window:
  - Stimulus: select1=0, select2=15, ro_in[0] period 8 clocks, ro_in[15] period 16 clocks, reset=1, enable=1.
  - Required: after 4095 clocks done=1 and clockcounter_out=4095; counter1_out=511±1; counter2_out=255±1; puf_out=1.
  - 100 further clocks → all values unchanged.
- Swapped selects: same stimulus with select1=15, select2=0 → counter1_out≈255, counter2_out≈511, puf_out=0.
- Enable gating: enable=1 for 100 clocks, then 0 for 200 clocks with inputs toggling → clockcounter_out stays 100 and channel counts hold. Re-enable → counting resumes with no extra edge.
- Equal and static inputs:
  - select1=select2=5 → counter1_out==counter2_out and puf_out=1 at done.
  - Channel fed by a constant-0 or constant-1 input → count 0.
- Saturation: channel input toggling at clock/4 for a full window → count ≤1024. Force count near 4095 and keep edges arriving → count holds at 4095, no wrap.
